// File: rtl/mmio_button_ctrl.sv
// Memory-mapped button/switch input block: sync, debounce, sticky press events, W1C event register.
// Optional interrupt output and CTRL mask register are built when INPUT_IRQ_EN is defined.
module mmio_button_ctrl #(
  parameter int          N_BTN     = 4,
  parameter int          SW_W      = 2,
  parameter int          DEB_CYC   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BTN-1:0]  btn_n,
  input  logic [SW_W-1:0]   sw,
  input  logic [31:0]       adr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic              sel,
  output logic [31:0]       rdata
`ifdef INPUT_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int             CW      = $clog2(DEB_CYC);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYC - 1);

  logic [N_BTN-1:0] btn_s1, btn_s2;
  logic [SW_W-1:0]  sw_s1, sw_s2;
  logic [N_BTN-1:0] db, db_next;
  logic [N_BTN-1:0] evt, evt_next;
  logic [N_BTN-1:0] miss, miss_next;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] clr_evt, clr_miss;
  logic [CW-1:0]    cnt      [N_BTN];
  logic [CW-1:0]    cnt_next [N_BTN];
  logic             wr_event;
  logic             unused_ok;

`ifdef INPUT_IRQ_EN
  logic [N_BTN-1:0] mask;
  logic             wr_ctrl;
  assign wr_ctrl = we & sel & (adr[3:2] == 2'd3);
`endif

  assign sel      = (adr[31:4] == BASE_ADDR[31:4]);
  assign wr_event = we & sel & (adr[3:2] == 2'd1);
  assign unused_ok = ^{adr[1:0], wdata};

  // Per-button debounce: a new level is accepted only after DEB_CYC disagreeing cycles.
  always_comb begin
    db_next = db;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_next[i] = cnt[i];
      if (~btn_s2[i] == db[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        db_next[i]  = ~btn_s2[i];
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_comb begin
    press     = db_next & ~db;
    clr_evt   = wr_event ? wdata[N_BTN-1:0]  : '0;
    clr_miss  = wr_event ? wdata[16 +: N_BTN] : '0;
    // A press always wins over a same-cycle clear, and then does not count as missed.
    evt_next  = (evt & ~clr_evt) | press;
    miss_next = (miss & ~clr_miss) | (press & evt & ~clr_evt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= '1;
      btn_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
      db     <= '0;
      evt    <= '0;
      miss   <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
`ifdef INPUT_IRQ_EN
      mask   <= '0;
      irq    <= 1'b0;
`endif
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      db     <= db_next;
      evt    <= evt_next;
      miss   <= miss_next;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= cnt_next[i];
`ifdef INPUT_IRQ_EN
      if (wr_ctrl) mask <= wdata[N_BTN-1:0];
      irq <= |(evt_next & mask);
`endif
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (adr[3:2])
        2'd0: rdata[N_BTN-1:0] = db;
        2'd1: begin
          rdata[N_BTN-1:0]  = evt;
          rdata[16 +: N_BTN] = miss;
        end
        2'd2: rdata[SW_W-1:0] = sw_s2;
`ifdef INPUT_IRQ_EN
        2'd3: rdata[N_BTN-1:0] = mask;
`endif
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_button_ctrl.sv
// Bench for mmio_button_ctrl (N_BTN=4, SW_W=2, DEB_CYC=4, BASE_ADDR=0x400); define INPUT_IRQ_EN to cover irq/CTRL.
module tb_mmio_button_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn_n;
  logic [1:0]  sw;
  logic [31:0] adr;
  logic        we;
  logic [31:0] wdata;
  logic        sel;
  logic [31:0] rdata;
`ifdef INPUT_IRQ_EN
  logic        irq;
`endif

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mmio_button_ctrl #(
    .N_BTN(4), .SW_W(2), .DEB_CYC(4), .BASE_ADDR(32'h0000_0400)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .sw(sw),
    .adr(adr), .we(we), .wdata(wdata), .sel(sel), .rdata(rdata)
`ifdef INPUT_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adr = a; wdata = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; wdata = '0; adr = '0;
  endtask

  task automatic push(input string name, input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    e.name = name; e.a = a; e.v = v;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b1; btn_n = 4'hF; sw = 2'b11; we = 1'b0; adr = '0; wdata = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    push("rst_status", 32'h400, 32'h0);
    push("rst_event",  32'h404, 32'h0);
    push("rst_ctrl",   32'h40C, 32'h0);
    push("sw_one_edge", 32'h408, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
    tick(1);
    push("sw_two_edges", 32'h408, 32'h3);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
    adr = 32'h0000_040C; #1; n_cmp++;
    if (sel !== 1'b1) begin n_err++; $display("FAIL sel_hit: sel=%b expected 1", sel); end
    adr = 32'h0000_0410; #1; n_cmp++;
    if (sel !== 1'b0) begin n_err++; $display("FAIL sel_miss: sel=%b expected 0", sel); end
`ifdef INPUT_IRQ_EN
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: irq=%b expected 0", irq); end
`endif
    adr = '0;
  endtask

  task automatic test_debounce_press;
    exp_t e;
    btn_n = 4'hE;
    tick(5);
    push("deb_e4_status", 32'h400, 32'h0);
    push("deb_e4_event",  32'h404, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
    tick(1);
    push("deb_e5_status", 32'h400, 32'h1);
    push("deb_e5_event",  32'h404, 32'h1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
    btn_n = 4'hF;
    tick(6);
    push("rel_status", 32'h400, 32'h0);
    push("rel_event",  32'h404, 32'h1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
  endtask

  task automatic test_glitch;
    exp_t e;
    btn_n = 4'hD;
    tick(3);
    btn_n = 4'hF;
    tick(8);
    push("glitch_status", 32'h400, 32'h0);
    push("glitch_event",  32'h404, 32'h1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
  endtask

  task automatic test_missed_press;
    exp_t e;
    btn_n = 4'hE;
    tick(6);
    push("miss_status", 32'h400, 32'h1);
    push("miss_event",  32'h404, 32'h0001_0001);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
    btn_n = 4'hF;
    tick(6);
    wr(32'h0000_0504, 32'h0001_0001);
    wr(32'h0000_0400, 32'hFFFF_FFFF);
    push("unsel_write", 32'h404, 32'h0001_0001);
    push("ro_write",    32'h400, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
    wr(32'h0000_0404, 32'h0001_0000);
    push("w1c_miss_only", 32'h404, 32'h1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
    wr(32'h0000_0407, 32'h0000_0001);
    push("w1c_evt", 32'h404, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
  endtask

  task automatic test_set_wins;
    exp_t e;
    btn_n = 4'hE;
    tick(6);
    btn_n = 4'hF;
    tick(6);
    push("pre_event", 32'h404, 32'h1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
    btn_n = 4'hE;
    tick(5);
    wr(32'h0000_0404, 32'h0000_0001);
    push("setwin_event",  32'h404, 32'h1);
    push("setwin_status", 32'h400, 32'h1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
    btn_n = 4'hF;
    tick(6);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    btn_n = 4'h5;
    sw = 2'b01;
    tick(6);
    push("multi_status", 32'h400, 32'hA);
    push("multi_event",  32'h404, 32'hB);
    push("multi_switch", 32'h408, 32'h1);
    push("unsel_read",   32'h0000_0800, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
    btn_n = 4'hF;
    tick(6);
    wr(32'h0000_0404, 32'hFFFF_FFFF);
    push("clear_all", 32'h404, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
  endtask

  task automatic test_ctrl;
    exp_t e;
    wr(32'h0000_040C, 32'h0000_0004);
`ifdef INPUT_IRQ_EN
    push("ctrl_rw", 32'h40C, 32'h4);
`else
    push("ctrl_ro", 32'h40C, 32'h0);
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
`ifdef INPUT_IRQ_EN
    btn_n = 4'hB;
    tick(5);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: irq=%b expected 0", irq); end
    tick(1);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: irq=%b expected 1", irq); end
    push("irq_event", 32'h404, 32'h4);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
    btn_n = 4'hF;
    tick(6);
    btn_n = 4'h7;
    tick(6);
    btn_n = 4'hF;
    tick(6);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_masked_hold: irq=%b expected 1", irq); end
    wr(32'h0000_0404, 32'h0000_0004);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: irq=%b expected 0", irq); end
    push("irq_masked_evt", 32'h404, 32'h8);
    while (sb.size() > 0) begin
      e = sb.pop_front(); adr = e.a; #1; n_cmp++;
      if (rdata !== e.v) begin n_err++; $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.v); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_debounce_press();
    test_glitch();
    test_missed_press();
    test_set_wins();
    test_back_to_back();
    test_ctrl();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
